exe_mem_skid_reg: RTL
=====================

Name: exe_mem_skid_reg

Overview:
- Pipeline boundary between the EXE stage and the memory stage (cache controller + SRAM controller).
- Two-entry skid buffer with a valid/ready handshake toward EXE, so a multi-cycle cache miss stalls EXE without a combinational ready path crossing the stage.
- Holds the memory request (mem_read/mem_write, address, data) stable until the memory stage asserts ready.
- Passes writeback control through to MEM/WB.
- Counts stall cycles for performance debug.

Parameters:
- DW, 32, data/address width.
- RW, 4, destination register index width.
- CW, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- exe_valid  in  1  EXE presents a valid instruction this cycle.
- exe_ready  out  1  buffer accepts EXE payload; registered.
- exe_wb_en  in  1  writeback enable.
- exe_mem_r_en  in  1  load.
- exe_mem_w_en  in  1  store.
- exe_alu_result  in  DW  ALU result / effective address.
- exe_val_rm  in  DW  store data.
- exe_dest  in  RW  destination register.
- mem_read  out  1  load request to memory stage.
- mem_write  out  1  store request to memory stage.
- address  out  DW  request address (head alu_result).
- data  out  DW  store data (head val_rm).
- mem_ready  in  1  memory stage done/idle.
- out_valid  out  1  head entry valid.
- out_fire  out  1  head retires this cycle (MEM/WB capture strobe).
- out_wb_en  out  1  head wb_en.
- out_dest  out  RW  head dest.
- stall_cnt  out  CW  cycles with out_valid=1, memory op pending, mem_ready=0.

Behaviour:
- Storage: head register (H) feeds all outputs; skid register (S). Occupancy count in {0,1,2} acts as state: EMPTY, ONE, FULL.
- Entry accepted (in_fire) when exe_valid & exe_ready.
- Retirement rule: mem_op = H.mem_r_en | H.mem_w_en. out_fire = out_valid & (~mem_op | mem_ready). A non-memory entry retires the cycle it reaches H.
- Request outputs:
  - mem_read = out_valid & H.mem_r_en; mem_write = out_valid & H.mem_w_en.
  - address and data equal H fields.
  - All four are stable from first presentation until out_fire; they never change while a request is pending.
- Transitions:
  - EMPTY: in_fire -> load H, go ONE.
  - ONE, in_fire & out_fire: load H from input, stay ONE.
  - ONE, in_fire & ~out_fire: load S, go FULL.
  - ONE, ~in_fire & out_fire: go EMPTY.
  - FULL, out_fire: H <= S, go ONE. No input is accepted in FULL.
- exe_ready: registered; next value = (next count < 2). It is 1 out of reset. It is 0 in FULL.
- Fall-through: none. An accepted entry is visible at H the next cycle at the earliest, giving a minimum latency of 1 cycle.
- Payload with exe_valid=0: ignored. Registers load only on in_fire; a bubble never reaches H.
- Simultaneous events:
  - ONE with in_fire & out_fire: the new entry replaces H with no bubble.
  - FULL with out_fire and exe_valid: the input is not accepted that cycle (exe_ready=0).
- stall_cnt: increments when out_valid & mem_op & ~mem_ready. It saturates at all-ones and never wraps.
- Reset (rst=0 at a clock edge), including mid-request:
  - count=0; exe_ready=1; out_valid, mem_read, mem_write, out_fire = 0.
  - address, data, out_dest = 0; out_wb_en=0; stall_cnt=0.
  - A pending SRAM request is abandoned. The memory stage is reset by the same rst.
- Sanity: H.mem_r_en & H.mem_w_en both set is illegal input. The assertion bench flags it and the RTL forwards both unchanged.

Decomposition:
- Shared package (defines file): the DW/RW defaults, the occupancy encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2, and the payload bundle field widths, shared with the EXE and MEM/WB registers.
- One sub-module is natural: pipe_entry_reg. It is a payload register with a load enable and synchronous active-low clear, instantiated twice (H, S).
- Control (count, ready, fire, stall counter) lives in the top.

Test Plan:
- Reset: drive rst=0 for 2 cycles with exe_valid=1 -> exe_ready=1, out_valid=0, mem_read=0, stall_cnt=0. No entry is captured.
- ALU-only stream:
  - Stimulus: 4 back-to-back entries, mem_r_en=mem_w_en=0, dest=1..4, mem_ready=0.
  - Response: out_fire high each cycle starting 1 cycle after the first accept; out_dest sequence 1,2,3,4; exe_ready stays 1; stall_cnt stays 0.
- Load miss:
  - Stimulus: load, alu_result=0x0000_0400, followed by an ALU op with dest=5; mem_ready=0 for 6 cycles, then 1.
  - Response: mem_read=1 and address=0x400 stable for 7 cycles; the second entry goes to S; exe_ready=0 while FULL.
  - After ready: the load retires, then dest=5 retires next cycle; stall_cnt=6.
- Store:
  - Stimulus: alu_result=0x10, val_rm=0xDEADBEEF, mem_ready rises after 3 cycles.
  - Response: mem_write=1, data=0xDEADBEEF held for 4 cycles; out_fire is a single pulse; out_wb_en=0.
- Simultaneous in/out in ONE: with mem_ready=1 and a continuous stream of loads -> one retire per cycle, no bubbles, count stays ONE.
- Reset mid-miss: assert rst=0 while mem_read=1 in FULL -> next cycle count=0, mem_read=0, exe_ready=1, stall_cnt=0.

Source files
------------

// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared widths and occupancy encodings for the EXE -> MEM boundary.
// Also used by the EXE and MEM/WB pipeline registers so their payload layouts agree.
package exe_mem_skid_reg_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 4;
  localparam int CW_DEF = 32;

  // Payload control bits: wb_en, mem_r_en, mem_w_en.
  localparam int CTRL_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/exe_mem_skid_reg_if.sv
// EXE-side handshake, memory request and MEM/WB pass-through bundle.
// slave = the skid register, master = the surrounding pipeline.
interface exe_mem_skid_reg_if
  import exe_mem_skid_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
);
  logic          exe_valid;
  logic          exe_ready;
  logic          exe_wb_en;
  logic          exe_mem_r_en;
  logic          exe_mem_w_en;
  logic [DW-1:0] exe_alu_result;
  logic [DW-1:0] exe_val_rm;
  logic [RW-1:0] exe_dest;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] address;
  logic [DW-1:0] data;
  logic          mem_ready;
  logic          out_valid;
  logic          out_fire;
  logic          out_wb_en;
  logic [RW-1:0] out_dest;
  logic [CW-1:0] stall_cnt;

  modport slave (
    input  exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    input  exe_alu_result, exe_val_rm, exe_dest, mem_ready,
    output exe_ready, mem_read, mem_write, address, data,
    output out_valid, out_fire, out_wb_en, out_dest, stall_cnt
  );

  modport master (
    output exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
    output exe_alu_result, exe_val_rm, exe_dest, mem_ready,
    input  exe_ready, mem_read, mem_write, address, data,
    input  out_valid, out_fire, out_wb_en, out_dest, stall_cnt
  );

endinterface

// File: rtl/exe_mem_skid_reg_pipe_entry_reg.sv
// Payload register with load enable and synchronous active-low clear.
// Latency 1 cycle; no backpressure of its own, the owner decides when to load.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)
      q <= '0;
    else if (ld)
      q <= d;
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// Two-entry EXE->MEM skid buffer; latency 1 cycle min, no fall-through.
// Backpressure: registered exe_ready drops when both entries are occupied; head holds until mem_ready.
module exe_mem_skid_reg
  import exe_mem_skid_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  exe_mem_skid_reg_if.slave     bus
);

  typedef struct packed {
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] val_rm;
    logic [RW-1:0] dest;
  } entry_t;

  entry_t        in_e, h_d, h_q, s_q;
  occ_e          count, count_nxt;
  logic          exe_ready_q;
  logic [CW-1:0] stall_q;
  logic          out_valid, mem_op, in_fire, out_fire;
  logic          h_ld, s_ld;

  assign in_e = {bus.exe_wb_en, bus.exe_mem_r_en, bus.exe_mem_w_en,
                 bus.exe_alu_result, bus.exe_val_rm, bus.exe_dest};

  assign out_valid = (count != EMPTY);
  assign mem_op    = h_q.mem_r_en | h_q.mem_w_en;
  assign in_fire   = bus.exe_valid & exe_ready_q;
  assign out_fire  = out_valid & (~mem_op | bus.mem_ready);

  always_comb begin
    count_nxt = count;
    h_ld      = 1'b0;
    s_ld      = 1'b0;
    case (count)
      EMPTY: if (in_fire) begin
        h_ld      = 1'b1;
        count_nxt = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          h_ld = 1'b1;
        end else if (in_fire) begin
          s_ld      = 1'b1;
          count_nxt = FULL;
        end else if (out_fire) begin
          count_nxt = EMPTY;
        end
      end
      FULL: if (out_fire) begin
        h_ld      = 1'b1;
        count_nxt = ONE;
      end
      default: count_nxt = EMPTY;
    endcase
  end

  // Head refills from the skid entry when draining FULL, otherwise from EXE.
  assign h_d = (count == FULL) ? s_q : in_e;

  pipe_entry_reg #(.W($bits(entry_t))) u_head (
    .clk (clk),
    .rst (rst),
    .ld  (h_ld),
    .d   (h_d),
    .q   (h_q)
  );

  pipe_entry_reg #(.W($bits(entry_t))) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (s_ld),
    .d   (in_e),
    .q   (s_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= EMPTY;
      exe_ready_q <= 1'b1;
      stall_q     <= '0;
    end else begin
      count       <= count_nxt;
      exe_ready_q <= (count_nxt != FULL);
      if (out_valid && mem_op && !bus.mem_ready && !(&stall_q))
        stall_q <= stall_q + CW'(1);
    end
  end

  assign bus.exe_ready = exe_ready_q;
  assign bus.mem_read  = out_valid & h_q.mem_r_en;
  assign bus.mem_write = out_valid & h_q.mem_w_en;
  assign bus.address   = h_q.alu_result;
  assign bus.data      = h_q.val_rm;
  assign bus.out_valid = out_valid;
  assign bus.out_fire  = out_fire;
  assign bus.out_wb_en = out_valid & h_q.wb_en;
  assign bus.out_dest  = h_q.dest;
  assign bus.stall_cnt = stall_q;

endmodule
